// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - UART RX byte-stream frame decoder (sync, cmd, payload, XOR checksum)
// Optional inter-byte timeout compiled in with `define FRAME_TIMEOUT_EN.
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         PAYLOAD_BYTES = 2,
  parameter int         TIMEOUT_CYC   = 65000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_rx_empty,
  input  logic [7:0]                   i_r_data,
  output logic                         o_rd_uart,
  output logic                         o_frame_valid,
  output logic [7:0]                   o_cmd,
  output logic [8*PAYLOAD_BYTES-1:0]   o_payload,
  output logic                         o_frame_err,
  output logic [1:0]                   o_err_code
);

  localparam int PW    = 8 * PAYLOAD_BYTES;
  localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_CHK} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_cmd_sh;
  logic [PW-1:0]    r_pl_sh;
  logic [7:0]       r_chk;
  logic [IDX_W-1:0] r_idx;
  logic             w_pop;
  logic             w_tmo;
  logic [PW-1:0]    w_pl_shift;

  // The FIFO is drained unconditionally; gating with reset keeps it untouched while held in reset.
  assign w_pop      = ~i_rx_empty & i_rst_n;
  assign o_rd_uart  = w_pop;
  assign w_pl_shift = PW'({r_pl_sh, i_r_data});

`ifdef FRAME_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  // Fires on the idle cycle that would carry the counter to the threshold.
  assign w_tmo = (r_state != S_IDLE) && i_rx_empty && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_pop || w_tmo || (r_state == S_IDLE)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    if (w_tmo) begin
      w_next = S_IDLE;
    end else if (w_pop) begin
      case (r_state)
        S_IDLE:  if (i_r_data == SYNC_BYTE) w_next = S_CMD;
        S_CMD:   w_next = S_DATA;
        S_DATA:  if (r_idx == IDX_W'(PAYLOAD_BYTES - 1)) w_next = S_CHK;
        S_CHK:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cmd_sh      <= '0;
      r_pl_sh       <= '0;
      r_chk         <= '0;
      r_idx         <= '0;
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      o_cmd         <= '0;
      o_payload     <= '0;
      o_err_code    <= 2'b00;
    end else begin
      r_state       <= w_next;
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      if (w_tmo) begin
        o_frame_err <= 1'b1;
        o_err_code  <= 2'b10;
      end else if (w_pop) begin
        case (r_state)
          S_CMD: begin
            r_cmd_sh <= i_r_data;
            r_chk    <= i_r_data;
            r_idx    <= '0;
          end
          S_DATA: begin
            r_pl_sh <= w_pl_shift;
            r_chk   <= r_chk ^ i_r_data;
            r_idx   <= r_idx + 1'b1;
          end
          S_CHK: begin
            // Visible outputs move only on a verified frame.
            if (i_r_data == r_chk) begin
              o_frame_valid <= 1'b1;
              o_cmd         <= r_cmd_sh;
              o_payload     <= r_pl_sh;
            end else begin
              o_frame_err <= 1'b1;
              o_err_code  <= 2'b01;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb/tb_uart_frame_decoder.sv - scoreboard bench for uart_frame_decoder (PAYLOAD_BYTES=2, TIMEOUT_CYC=50)
module tb_uart_frame_decoder;

  typedef struct {
    logic        err;
    logic [1:0]  code;
    logic [7:0]  cmd;
    logic [15:0] pl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_empty = 1'b1;
  logic [7:0]  r_data = 8'h00;
  logic        rd_uart;
  logic        frame_valid;
  logic [7:0]  cmd;
  logic [15:0] payload;
  logic        frame_err;
  logic [1:0]  err_code;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [7:0]  fifo[$];
  exp_t        exp_q[$];
  int          vcyc[$];
  logic [7:0]  m_cmd = 8'h00;
  logic [15:0] m_pl = 16'h0000;
  logic [1:0]  m_code = 2'b00;

  uart_frame_decoder #(
    .SYNC_BYTE(8'hA5),
    .PAYLOAD_BYTES(2),
    .TIMEOUT_CYC(50)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_rx_empty(rx_empty),
    .i_r_data(r_data),
    .o_rd_uart(rd_uart),
    .o_frame_valid(frame_valid),
    .o_cmd(cmd),
    .o_payload(payload),
    .o_frame_err(frame_err),
    .o_err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // FIFO model: head pops on the edge where the decoder sees it non-empty.
  always @(posedge clk) begin
    logic [7:0] tmp;
    cyc++;
    if (rst_n && !rx_empty && fifo.size() != 0) tmp = fifo.pop_front();
    #1;
    rx_empty = (fifo.size() == 0);
    if (fifo.size() != 0) r_data = fifo[0];
  end

  always @(negedge clk) begin
    exp_t e;
    check("rd_uart", {31'd0, rd_uart}, {31'd0, rst_n & ~rx_empty});
    if (frame_valid || frame_err) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_strobe observed valid=%b err=%b expected none", frame_valid, frame_err);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("strobe", {30'd0, frame_valid, frame_err}, {30'd0, ~e.err, e.err});
        check("err_code", {30'd0, err_code}, {30'd0, e.code});
        check("cmd", {24'd0, cmd}, {24'd0, e.cmd});
        check("payload", {16'd0, payload}, {16'd0, e.pl});
        if (frame_valid) vcyc.push_back(cyc);
      end
    end
  end

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic push5(input logic [7:0] b0, b1, b2, b3, b4);
    push(b0); push(b1); push(b2); push(b3); push(b4);
  endtask

  task automatic expect_good(input logic [7:0] c, input logic [15:0] p);
    m_cmd = c;
    m_pl  = p;
    exp_q.push_back('{1'b0, m_code, c, p});
  endtask

  task automatic expect_err(input logic [1:0] code);
    m_code = code;
    exp_q.push_back('{1'b1, code, m_cmd, m_pl});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && (fifo.size() != 0 || exp_q.size() != 0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(tag, {30'd0, fifo.size() == 0, exp_q.size() == 0}, 32'd3);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    check("rst_cmd", {24'd0, cmd}, 32'd0);
    check("rst_payload", {16'd0, payload}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    push5(8'hA5, 8'h10, 8'h12, 8'h34, 8'h36);
    expect_good(8'h10, 16'h1234);
    drain("good_frame");

    push5(8'hA5, 8'h10, 8'h12, 8'h34, 8'h37);
    expect_err(2'b01);
    drain("bad_checksum");

    push(8'h00); push(8'hFF);
    push5(8'hA5, 8'h20, 8'hA5, 8'h01, 8'h84);
    expect_good(8'h20, 16'hA501);
    drain("garbage_embedded_sync");

    push(8'hA5); push(8'h10);
`ifdef FRAME_TIMEOUT_EN
    expect_err(2'b10);
    drain("timeout");
`else
    repeat (60) @(negedge clk);
    push(8'h12); push(8'h34); push(8'h36);
    expect_good(8'h10, 16'h1234);
    drain("stall_resume");
`endif
    push5(8'hA5, 8'h50, 8'h00, 8'hFF, 8'hAF);
    expect_good(8'h50, 16'h00FF);
    drain("after_stall");

    vcyc.delete();
    push5(8'hA5, 8'h30, 8'hAB, 8'hCD, 8'h56);
    push5(8'hA5, 8'h40, 8'h01, 8'h02, 8'h43);
    expect_good(8'h30, 16'hABCD);
    expect_good(8'h40, 16'h0102);
    drain("back_to_back");
    check("b2b_count", vcyc.size(), 32'd2);
    if (vcyc.size() == 2) check("b2b_spacing", vcyc[1] - vcyc[0], 32'd5);

    push(8'hA5); push(8'h10); push(8'h12);
    for (int i = 0; i < 20 && fifo.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    push(8'h55);
    repeat (3) @(negedge clk);
    check("mid_rst_valid", {31'd0, frame_valid}, 32'd0);
    check("mid_rst_err", {31'd0, frame_err}, 32'd0);
    check("mid_rst_cmd", {24'd0, cmd}, 32'd0);
    check("mid_rst_payload", {16'd0, payload}, 32'd0);
    check("mid_rst_err_code", {30'd0, err_code}, 32'd0);
    check("mid_rst_fifo_held", fifo.size(), 32'd1);
    m_cmd = 8'h00; m_pl = 16'h0000; m_code = 2'b00;
    rst_n = 1'b1;
    push5(8'hA5, 8'h10, 8'h12, 8'h34, 8'h36);
    expect_good(8'h10, 16'h1234);
    drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Byte-stream reader for the UART receive path: drains the UART RX FIFO (`rx_empty` / `r_data` / `rd_uart` handshake) and reassembles fixed-length command frames sent by the peer board. Each frame is a sync byte, a command byte, `PAYLOAD_BYTES` data bytes and an XOR checksum. Good frames are presented to game logic as a one-cycle `frame_valid` strobe with held `cmd` / `payload`. Malformed or stalled frames are dropped with a one-cycle `frame_err` strobe and an error code.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `PAYLOAD_BYTES`, 2, data bytes per frame (1..4).
- `TIMEOUT_CYC`, 65000, max idle clocks between bytes inside a frame.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `rx_empty`  in  1  UART RX FIFO empty flag.
- `r_data`  in  8  UART RX FIFO head byte, valid while `rx_empty`=0.
- `rd_uart`  out  1  FIFO pop; combinational.
- `frame_valid`  out  1  one-cycle strobe: good frame decoded.
- `cmd`  out  8  command byte of the last good frame.
- `payload`  out  8*PAYLOAD_BYTES  data of the last good frame; first received byte in the MSBs.
- `frame_err`  out  1  one-cycle strobe: frame dropped.
- `err_code`  out  2  reason for the last error: 01 checksum, 10 timeout; held until the next error.

## Operation
- `rd_uart = ~rx_empty` whenever `rst_n`=1. Every byte at the FIFO head is consumed in the cycle it is popped. There is no backpressure.
- FSM states:
  - IDLE: on pop, `r_data==SYNC_BYTE` → CMD. Any other byte is discarded silently with no error.
  - CMD: on pop, latch the byte into a shadow command register and initialise `chk` to that byte → DATA.
  - DATA: on pop, shift the byte into the shadow payload and set `chk ^= byte`. Index counts 0..PAYLOAD_BYTES-1. After the last data byte → CHK.
  - CHK: on pop, if `byte==chk`, copy the shadows to `cmd` / `payload` and pulse `frame_valid`. Otherwise pulse `frame_err` with `err_code`=01. Either way → IDLE.
- The checksum covers the command and data bytes only; the sync byte is excluded.
- `SYNC_BYTE` seen in CMD, DATA or CHK is treated as ordinary data. There is no mid-frame resync.
- `cmd` and `payload` change only on a good frame. Dropped frames leave them untouched.

## Timing
- Reset values: FSM in IDLE. `frame_valid`=0, `frame_err`=0, `cmd`=0, `payload`=0, `err_code`=00, checksum, index and timeout counter all 0.
- `rd_uart` stays 0 during reset.
- Latency: `frame_valid` / `frame_err` is registered and asserts in the cycle after the checksum byte's pop edge. `cmd` / `payload` update on the same edge.
- Throughput: one byte per clock. Back-to-back frames are supported with no dead cycle; CHK → IDLE → CMD can take consecutive cycles.
- Reset asserted mid-frame: the partial frame is discarded, with no `frame_err`. Decoding restarts in IDLE.
- Timeout counter behaviour:
  - Width is `$clog2(TIMEOUT_CYC+1)`.
  - It clears on every pop and increments each cycle when state≠IDLE and `rx_empty`=1.
  - When it reaches `TIMEOUT_CYC`: pulse `frame_err` with `err_code`=10 next cycle, go to IDLE and clear the counter.
  - A byte available in the threshold cycle wins, because the counter does not advance when `rx_empty`=0.
  - The counter holds at 0 while in IDLE.

## Configuration
- `FRAME_TIMEOUT_EN` defined: the inter-byte timeout is compiled in exactly as described above.
- `FRAME_TIMEOUT_EN` undefined:
  - The counter logic is removed and a stalled frame waits indefinitely.
  - `err_code`=10 is never produced.
  - `TIMEOUT_CYC` is ignored.

## Test plan
All scenarios use PAYLOAD_BYTES=2 and model the FIFO as a queue.
- Good frame: push A5 10 12 34 36 → one `frame_valid` pulse; `cmd`=10, `payload`=1234, `frame_err` never asserted.
- Bad checksum: push A5 10 12 34 37 → `frame_err` pulse with `err_code`=01; `cmd` and `payload` keep their previous values.
- Leading garbage and embedded sync: push 00 FF A5 20 A5 01 84 → no error on 00 or FF; `frame_valid` with `cmd`=20, `payload`=A501 (checksum 20^A5^01=84).
- Timeout, with the macro defined and TIMEOUT_CYC=50:
  - Push A5 10, then idle 50 cycles → `frame_err` with `err_code`=10.
  - Then push a good frame → `frame_valid`.
- Back-to-back: push two good frames with no gap → two `frame_valid` pulses 5 cycles apart, correct `cmd` / `payload` each time.
- Reset mid-frame: push A5 10 12, assert `rst_n`=0 for 3 cycles → all outputs return to zero with no strobe; a subsequent good frame decodes normally.
